ip_decoder: RTL and testbench
=============================

Name: ip_decoder

Overview:
- Receive side of the IP layer; counterpart of the IP encoder.
- Accepts a 32-bit word stream carrying one IPv4 packet, parses and registers the 20-byte base header, and verifies the header checksum.
- Skips IP options and forwards payload words to the UDP/TCP decoders with a write strobe, payload length and end-of-packet pulse.
- Sits between the MAC/link-layer FIFO reader and the transport-layer decoders.

Parameters:
- LOCAL_IP, 32'hC0A8_0001, this node's address; used only when IP_DEST_FILTER_EN is defined.
- CHECK_VERSION, 1, when 1 a version field other than 4 is a header error; when 0 version is not checked.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- data  in  32  packet word, big-endian; word 0 is {version, IHL, type_of_ser, total_length}.
- data_av  in  1  data holds a valid word this cycle.
- version, IHL  out  4 each  registered header fields.
- type_of_ser, time_to_live, protocol  out  8 each  registered header fields.
- total_length, identification  out  16 each  registered header fields.
- flag  out  3  registered header field.
- frag_offset  out  13  registered header field.
- checksum_out  out  16  received header checksum field.
- src_ip, dest_ip  out  32 each  registered header fields.
- hdr_valid  out  1  one-cycle pulse: header accepted, all field outputs valid.
- pkg_data  out  32  payload word.
- wr_en  out  1  pkg_data valid.
- len_out  out  16  payload bytes = total_length - 4*IHL, valid from hdr_valid.
- fin  out  1  one-cycle pulse: packet complete.
- err_hdr  out  1  one-cycle pulse: malformed header.
- err_chk  out  1  one-cycle pulse: checksum failure.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; every output, word counter and checksum accumulator = 0.
- A word is consumed only on a clk edge with data_av=1. A data_av=0 cycle stalls the FSM in its current state and forces wr_en=0.
- States: IDLE, HEADER, OPTION, PAYLOAD, DROP, FIN.
- IDLE: the first data_av word is header word 0 -> HEADER with hdr_cnt=1. The accumulator is loaded with word[31:16] + word[15:0].
- HEADER: capture fields of words 0-4. Accumulate each word's two halfwords with one's-complement adds (end-around carry into a 16-bit sum).
- After word 4 is consumed, evaluate in this priority order:
  - err_hdr if (CHECK_VERSION and version!=4), or IHL<5, or total_length<4*IHL -> pulse err_hdr, go to IDLE.
  - err_chk if folded sum != 16'hFFFF -> pulse err_chk, go to DROP.
  - Otherwise pulse hdr_valid, load bytes_left=len_out and opt_left=IHL-5. Go to OPTION if opt_left!=0, else PAYLOAD, else FIN if len_out==0.
- Option words are included in the checksum. The checksum is therefore evaluated after the last option word (word 4*IHL/4-1), not after word 4. hdr_valid, err_chk and the OPTION->PAYLOAD transition follow that evaluation. err_hdr is still evaluated after word 4.
- OPTION: consume opt_left words, nothing output.
- PAYLOAD: each accepted word is registered to pkg_data with wr_en=1 on the next cycle (latency 1). bytes_left -= 4, saturating at 0. When the last word (bytes_left<=4) is accepted -> FIN.
- Trailing unused bytes of the last word are passed through unmasked.
- DROP: consume words with no output until bytes_left=0 (bytes_left loaded as total_length-4*IHL) -> IDLE. fin is not pulsed.
- FIN: fin=1 for exactly one cycle, coincident with the cycle after the final wr_en; then IDLE. Header field outputs hold until the next hdr_valid.
- A word arriving in the FIN cycle is ignored; the source must leave at least one idle cycle between packets.
- Pulse outputs (hdr_valid, fin, err_hdr, err_chk) are never asserted together.

Optional Feature:
- Macro IP_DEST_FILTER_EN.
- Defined: after a good checksum, dest_ip != LOCAL_IP and dest_ip != 32'hFFFF_FFFF -> DROP. No hdr_valid, no error pulse.
- Not defined: all well-formed packets are forwarded regardless of dest_ip.

Test Plan:
- Good packet: words 4500_0020, 1234_4000, 4011_A745, C0A8_0002, C0A8_0001, then payload 1111_1111, 2222_2222, 3333_3333 -> hdr_valid, len_out=12, protocol=8'h11; three wr_en beats with those words; fin one cycle after the third.
- Same packet with word 2 = 4011_A746 -> err_chk pulse, three payload words swallowed, no wr_en, no fin, next packet parsed normally.
- Header word 0 = 4400_0020 (IHL=4) -> err_hdr after word 4, no hdr_valid, FSM in IDLE.
- IHL=6 with a recomputed checksum and one option word DEAD_BEEF -> option not output, len_out = total_length-24, payload beats correct.
- data_av toggled 1/0 every cycle during the good packet -> identical pkg_data sequence; wr_en only the cycle after each accepted word.
- Reset asserted mid-PAYLOAD -> all outputs 0 immediately, then a fresh good packet decodes correctly. With IP_DEST_FILTER_EN, dest C0A8_0009 -> silent drop.

Source files
------------

// File: rtl/ip_decoder.sv
// ip_decoder
//   Receive side of the IP layer. Parses one IPv4 packet from a 32-bit
//   big-endian word stream, verifies the header checksum (options included),
//   skips option words and forwards payload words to the transport decoders.
//
// Build option:
//   IP_DEST_FILTER_EN  when defined, checksum-good packets whose destination
//                      is neither LOCAL_IP nor broadcast are dropped silently.
//
// Parameters:
//   LOCAL_IP       this node's address (used only with IP_DEST_FILTER_EN)
//   CHECK_VERSION  1: version != 4 is a header error, 0: version ignored
//
// Ports:
//   clk, reset            rising-edge clock, async active-high reset
//   data, data_av         input word and its valid qualifier
//   version .. dest_ip    header fields, updated together with hdr_valid
//   hdr_valid             1-cycle pulse: header accepted
//   pkg_data, wr_en       payload word, valid one cycle after acceptance
//   len_out               payload bytes (total_length - 4*IHL)
//   fin                   1-cycle pulse after the final wr_en
//   err_hdr, err_chk      1-cycle pulses: malformed header / bad checksum
module ip_decoder #(
  parameter logic [31:0] LOCAL_IP      = 32'hC0A8_0001,
  parameter int unsigned CHECK_VERSION = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data,
  input  logic        data_av,
  output logic [3:0]  version,
  output logic [3:0]  IHL,
  output logic [7:0]  type_of_ser,
  output logic [7:0]  time_to_live,
  output logic [7:0]  protocol,
  output logic [15:0] total_length,
  output logic [15:0] identification,
  output logic [2:0]  flag,
  output logic [12:0] frag_offset,
  output logic [15:0] checksum_out,
  output logic [31:0] src_ip,
  output logic [31:0] dest_ip,
  output logic        hdr_valid,
  output logic [31:0] pkg_data,
  output logic        wr_en,
  output logic [15:0] len_out,
  output logic        fin,
  output logic        err_hdr,
  output logic        err_chk
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_HEADER  = 3'd1;
  localparam logic [2:0] S_OPTION  = 3'd2;
  localparam logic [2:0] S_PAYLOAD = 3'd3;
  localparam logic [2:0] S_DROP    = 3'd4;
  localparam logic [2:0] S_FIN     = 3'd5;

`ifdef IP_DEST_FILTER_EN
  localparam logic FILTER_ON = 1'b1;
`else
  localparam logic FILTER_ON = 1'b0;
`endif

  logic [2:0]  r_state;
  logic [2:0]  r_hdr_cnt;
  logic [3:0]  r_opt_left;
  logic [15:0] r_acc;
  logic [15:0] r_bytes_left;
  logic [15:0] r_len_out;
  // r_hw: words being captured; r_pw: published copy, updated with hdr_valid
  logic [31:0] r_hw [0:4];
  logic [31:0] r_pw [0:4];
  logic [31:0] r_pkg_data;
  logic        r_wr_en;
  logic        r_hdr_valid;
  logic        r_fin;
  logic        r_err_hdr;
  logic        r_err_chk;

  logic [15:0] w_acc_nxt;
  logic [3:0]  w_ver;
  logic [3:0]  w_ihl;
  logic [15:0] w_tl;
  logic [15:0] w_hdr_bytes;
  logic [15:0] w_len;
  logic        w_hdr_bad;
  logic        w_sum_ok;
  logic [31:0] w_dest;
  logic        w_foreign;
  logic        w_accept;
  logic        w_last_word;
  logic [15:0] w_bytes_dec;
  logic        w_eval;

  function automatic logic [15:0] oc_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

  assign w_acc_nxt   = oc_add(oc_add(r_acc, data[31:16]), data[15:0]);
  assign w_ver       = r_hw[0][31:28];
  assign w_ihl       = r_hw[0][27:24];
  assign w_tl        = r_hw[0][15:0];
  assign w_hdr_bytes = {10'd0, w_ihl, 2'b00};
  assign w_len       = w_tl - w_hdr_bytes;
  assign w_hdr_bad   = ((CHECK_VERSION != 0) && (w_ver != 4'd4)) ||
                       (w_ihl < 4'd5) || (w_tl < w_hdr_bytes);
  assign w_sum_ok    = (w_acc_nxt == 16'hFFFF);
  // With IHL=5 the destination word is on the bus during evaluation
  assign w_dest      = (r_state == S_HEADER) ? data : r_hw[4];
  assign w_foreign   = (w_dest != LOCAL_IP) && (w_dest != '1);
  assign w_accept    = w_sum_ok && !(FILTER_ON && w_foreign);
  assign w_last_word = (r_bytes_left <= 16'd4);
  assign w_bytes_dec = w_last_word ? '0 : (r_bytes_left - 16'd4);

  // Checksum verdict happens on the last header/option word of the header
  assign w_eval = data_av &&
                  (((r_state == S_HEADER) && (r_hdr_cnt == 3'd4) && !w_hdr_bad && (w_ihl == 4'd5)) ||
                   ((r_state == S_OPTION) && (r_opt_left == 4'd1)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_hdr_cnt    <= '0;
      r_opt_left   <= '0;
      r_acc        <= '0;
      r_bytes_left <= '0;
      r_len_out    <= '0;
      for (int unsigned i = 0; i < 5; i++) begin
        r_hw[i] <= '0;
        r_pw[i] <= '0;
      end
      r_pkg_data   <= '0;
      r_wr_en      <= 1'b0;
      r_hdr_valid  <= 1'b0;
      r_fin        <= 1'b0;
      r_err_hdr    <= 1'b0;
      r_err_chk    <= 1'b0;
    end else begin
      r_wr_en     <= 1'b0;
      r_hdr_valid <= 1'b0;
      r_fin       <= 1'b0;
      r_err_hdr   <= 1'b0;
      r_err_chk   <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (data_av) begin
            r_hw[0]   <= data;
            r_acc     <= oc_add(data[31:16], data[15:0]);
            r_hdr_cnt <= 3'd1;
            r_state   <= S_HEADER;
          end
        end
        S_HEADER: begin
          if (data_av) begin
            for (int unsigned i = 1; i < 5; i++) begin
              if (r_hdr_cnt == 3'(i)) r_hw[i] <= data;
            end
            r_acc     <= w_acc_nxt;
            r_hdr_cnt <= r_hdr_cnt + 3'd1;
            if (r_hdr_cnt == 3'd4) begin
              if (w_hdr_bad) begin
                r_err_hdr <= 1'b1;
                r_state   <= S_IDLE;
              end else if (w_ihl != 4'd5) begin
                r_opt_left <= w_ihl - 4'd5;
                r_state    <= S_OPTION;
              end
            end
          end
        end
        S_OPTION: begin
          if (data_av) begin
            r_acc      <= w_acc_nxt;
            r_opt_left <= r_opt_left - 4'd1;
          end
        end
        S_PAYLOAD: begin
          if (data_av) begin
            r_pkg_data   <= data;
            r_wr_en      <= 1'b1;
            r_bytes_left <= w_bytes_dec;
            if (w_last_word) r_state <= S_FIN;
          end
        end
        S_DROP: begin
          if (r_bytes_left == 16'd0) begin
            r_state <= S_IDLE;
          end else if (data_av) begin
            r_bytes_left <= w_bytes_dec;
            if (w_last_word) r_state <= S_IDLE;
          end
        end
        S_FIN: begin
          r_fin   <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      // Header verdict overrides the state chosen above
      if (w_eval) begin
        r_bytes_left <= w_len;
        if (!w_sum_ok) begin
          r_err_chk <= 1'b1;
          r_state   <= S_DROP;
        end else if (!w_accept) begin
          r_state <= S_DROP;
        end else begin
          r_hdr_valid <= 1'b1;
          r_len_out   <= w_len;
          for (int unsigned i = 0; i < 4; i++) r_pw[i] <= r_hw[i];
          r_pw[4] <= w_dest;
          r_state <= (w_len == 16'd0) ? S_FIN : S_PAYLOAD;
        end
      end
    end
  end

  assign version        = r_pw[0][31:28];
  assign IHL            = r_pw[0][27:24];
  assign type_of_ser    = r_pw[0][23:16];
  assign total_length   = r_pw[0][15:0];
  assign identification = r_pw[1][31:16];
  assign flag           = r_pw[1][15:13];
  assign frag_offset    = r_pw[1][12:0];
  assign time_to_live   = r_pw[2][31:24];
  assign protocol       = r_pw[2][23:16];
  assign checksum_out   = r_pw[2][15:0];
  assign src_ip         = r_pw[3];
  assign dest_ip        = r_pw[4];
  assign hdr_valid      = r_hdr_valid;
  assign pkg_data       = r_pkg_data;
  assign wr_en          = r_wr_en;
  assign len_out        = r_len_out;
  assign fin            = r_fin;
  assign err_hdr        = r_err_hdr;
  assign err_chk        = r_err_chk;

endmodule

// File: tb/tb_ip_decoder.sv
// Scoreboard bench for ip_decoder: the driver computes each packet's expected
// events (kind, cycle, data) from IPv4 rules and queues them; a monitor pops
// and compares whenever the DUT raises a pulse or wr_en.
module tb_ip_decoder;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] data;
  logic        data_av;
  logic [3:0]  version, IHL;
  logic [7:0]  type_of_ser, time_to_live, protocol;
  logic [15:0] total_length, identification, checksum_out, len_out;
  logic [2:0]  flag;
  logic [12:0] frag_offset;
  logic [31:0] src_ip, dest_ip, pkg_data;
  logic        hdr_valid, wr_en, fin, err_hdr, err_chk;

  ip_decoder #(.LOCAL_IP(32'hC0A8_0001), .CHECK_VERSION(1)) dut (
    .clk(clk), .reset(reset), .data(data), .data_av(data_av),
    .version(version), .IHL(IHL), .type_of_ser(type_of_ser),
    .time_to_live(time_to_live), .protocol(protocol),
    .total_length(total_length), .identification(identification),
    .flag(flag), .frag_offset(frag_offset), .checksum_out(checksum_out),
    .src_ip(src_ip), .dest_ip(dest_ip), .hdr_valid(hdr_valid),
    .pkg_data(pkg_data), .wr_en(wr_en), .len_out(len_out), .fin(fin),
    .err_hdr(err_hdr), .err_chk(err_chk)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  localparam int K_EHDR = 0, K_ECHK = 1, K_HDR = 2, K_WR = 3, K_FIN = 4;
`ifdef IP_DEST_FILTER_EN
  localparam bit FILTER = 1'b1;
`else
  localparam bit FILTER = 1'b0;
`endif

  typedef struct {
    int           kind;
    int           cyc;
    logic [31:0]  d;
    logic [159:0] hdr;
    logic [15:0]  len;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] pkt[$];

  function automatic string kname(input int k);
    case (k)
      K_EHDR:  return "err_hdr";
      K_ECHK:  return "err_chk";
      K_HDR:   return "hdr_valid";
      K_WR:    return "wr_en";
      default: return "fin";
    endcase
  endfunction

  task automatic push_exp(input int kind, input int c, input logic [31:0] d,
                          input logic [159:0] h, input logic [15:0] len);
    exp_t e;
    e.kind = kind; e.cyc = c; e.d = d; e.hdr = h; e.len = len;
    sb.push_back(e);
  endtask

  task automatic check_event(input int k);
    exp_t e;
    bit ok;
    logic [159:0] h;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event actual=%s cycle=%0d required=no event", kname(k), cyc);
      return;
    end
    e = sb.pop_front();
    h = {version, IHL, type_of_ser, total_length, identification, flag, frag_offset,
         time_to_live, protocol, checksum_out, src_ip, dest_ip};
    ok = (e.kind == k) && (e.cyc == cyc);
    if (k == K_WR)  ok = ok && (pkg_data == e.d);
    if (k == K_HDR) ok = ok && (h == e.hdr) && (len_out == e.len);
    if (!ok) begin
      errors++;
      $display("FAIL event_%s actual kind=%s cycle=%0d data=%h hdr=%h len=%0d required kind=%s cycle=%0d data=%h hdr=%h len=%0d",
               kname(e.kind), kname(k), cyc, pkg_data, h, len_out,
               kname(e.kind), e.cyc, e.d, e.hdr, e.len);
    end
  endtask

  // Monitor: one scoreboard entry per asserted pulse or wr_en
  always @(negedge clk) begin
    logic [4:0] act;
    act = {fin, wr_en, hdr_valid, err_chk, err_hdr};
    for (int k = 0; k < 5; k++) if (act[k]) check_event(k);
  end

  task automatic check_zero(input string nm);
    logic [212:0] v;
    v = {version, IHL, type_of_ser, time_to_live, protocol, total_length, identification,
         flag, frag_offset, checksum_out, src_ip, dest_ip, hdr_valid, pkg_data, wr_en,
         len_out, fin, err_hdr, err_chk};
    checks++;
    if (v != '0) begin
      errors++;
      $display("FAIL %s actual=%h required=0", nm, v);
    end
  endtask

  // One's-complement sum of the first n packet words, folded to 16 bits
  function automatic logic [15:0] fold_hdr(input int n);
    int unsigned s;
    s = 0;
    for (int i = 0; i < n; i++) s += pkt[i][31:16] + pkt[i][15:0];
    while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
    return s[15:0];
  endfunction

  function automatic bit foreign(input logic [31:0] d);
    bit f;
    f = (d != 32'hC0A8_0001) && (d != 32'hFFFF_FFFF);
    return FILTER && f;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      data_av = 1'b0;
      data    = $urandom;
    end
  endtask

  // mode 0: back-to-back, 1: idle cycle before every word, 2: random gaps
  task automatic drive_word(input logic [31:0] w, input int mode, output int acc);
    int g;
    g = 0;
    if (mode == 1) g = 1;
    else if (mode == 2 && $urandom_range(0, 2) == 0) g = $urandom_range(1, 2);
    idle(g);
    @(negedge clk);
    data    = w;
    data_av = 1'b1;
    acc     = cyc + 1;
  endtask

  task automatic send_pkt(input int mode, input int maxw);
    logic [31:0]  w0;
    logic [159:0] hx;
    int ver, ihl, tl, len, nw, total, acc;
    bit bad, ok, fwd;
    w0  = pkt[0];
    ver = int'(w0[31:28]);
    ihl = int'(w0[27:24]);
    tl  = int'(w0[15:0]);
    bad = (ver != 4) || (ihl < 5) || (tl < 4 * ihl);
    len = tl - 4 * ihl;
    nw  = (len + 3) / 4;
    ok  = !bad && (fold_hdr(ihl) == 16'hFFFF);
    fwd = ok && !foreign(pkt[4]);
    hx  = {pkt[0], pkt[1], pkt[2], pkt[3], pkt[4]};
    total = bad ? 5 : ihl + nw;
    if (maxw < total) total = maxw;
    for (int i = 0; i < total; i++) begin
      drive_word(pkt[i], mode, acc);
      if (bad && i == 4) push_exp(K_EHDR, acc, '0, '0, '0);
      if (!bad && i == ihl - 1) begin
        if (!ok) push_exp(K_ECHK, acc, '0, '0, '0);
        else if (fwd) begin
          push_exp(K_HDR, acc, '0, hx, 16'(len));
          if (nw == 0) push_exp(K_FIN, acc + 1, '0, '0, '0);
        end
      end
      if (!bad && fwd && i >= ihl) begin
        push_exp(K_WR, acc, pkt[i], '0, '0);
        if (i == ihl + nw - 1) push_exp(K_FIN, acc + 1, '0, '0, '0);
      end
    end
    idle($urandom_range(1, 3));
  endtask

  task automatic set_csum(input int ihl);
    logic [31:0] t;
    t = pkt[2]; t[15:0] = 16'h0000; pkt[2] = t;
    t[15:0] = ~fold_hdr(ihl);
    pkt[2] = t;
  endtask

  // mode 0 good, 1 bad checksum, 2 bad version, 3 total_length < header
  task automatic build_pkt(input int ihl, input int lenb, input int mode);
    int tl, ver, r;
    logic [31:0] t;
    pkt.delete();
    tl  = (mode == 3) ? 4 * ihl - 1 - $urandom_range(0, 3) : 4 * ihl + lenb;
    ver = (mode == 2) ? $urandom_range(5, 15) : 4;
    pkt.push_back({ver[3:0], ihl[3:0], 8'($urandom), tl[15:0]});
    pkt.push_back($urandom);
    pkt.push_back({8'($urandom), 8'($urandom), 16'h0000});
    pkt.push_back($urandom);
    r = $urandom_range(0, 3);
    pkt.push_back(r == 0 ? 32'hC0A8_0001 : (r == 1 ? 32'hFFFF_FFFF : $urandom));
    for (int i = 5; i < ihl; i++) pkt.push_back($urandom);
    set_csum(ihl);
    if (mode == 1) begin
      t = pkt[2]; t[0] = ~t[0]; pkt[2] = t;
    end
    for (int i = 0; i < (lenb + 3) / 4; i++) pkt.push_back($urandom);
  endtask

  task automatic load_good();
    pkt = '{32'h4500_0020, 32'h1234_4000, 32'h4011_A745, 32'hC0A8_0002,
            32'hC0A8_0001, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int wait_n;
    reset   = 1'b1;
    data    = '0;
    data_av = 1'b0;
    #3;
    check_zero("reset_state");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // good packet
    load_good();
    send_pkt(0, 99);

    // bad checksum, then a normal packet
    load_good();
    pkt[2] = 32'h4011_A746;
    send_pkt(0, 99);
    load_good();
    send_pkt(0, 99);

    // IHL=4 header error, then a normal packet
    pkt = '{32'h4400_0020, 32'h1234_4000, 32'h4011_A745, 32'hC0A8_0002, 32'hC0A8_0001};
    send_pkt(0, 99);
    load_good();
    send_pkt(0, 99);

    // IHL=6 with one option word
    build_pkt(6, 12, 0);
    pkt[4] = 32'hC0A8_0001;
    pkt[5] = 32'hDEAD_BEEF;
    set_csum(6);
    send_pkt(0, 99);

    // data_av toggling
    load_good();
    send_pkt(1, 99);

    // reset in the middle of the payload
    load_good();
    send_pkt(0, 6);
    wait_n = 0;
    while (sb.size() != 0 && wait_n < 10) begin
      @(negedge clk);
      wait_n++;
    end
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check_zero("reset_mid_payload");
    @(negedge clk);
    reset = 1'b0;
    load_good();
    send_pkt(0, 99);

`ifdef IP_DEST_FILTER_EN
    load_good();
    pkt[4] = 32'hC0A8_0009;
    set_csum(5);
    send_pkt(0, 99);
`endif

    // randomized packets
    for (int n = 0; n < 40; n++) begin
      int r, m;
      r = $urandom_range(0, 7);
      m = (r == 0) ? 1 : (r == 1) ? 2 : (r == 2) ? 3 : 0;
      build_pkt($urandom_range(5, 7), $urandom_range(0, 20), m);
      send_pkt((n % 3 == 0) ? 0 : 2, 99);
    end

    idle(10);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d pending required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
